yutorina_spr_master: RTL and testbench
======================================

// Module: yutorina_spr_master
// PURPOSE
//  Initiator for the SPR access port: drives addr/wr/w_data into the SPR
//  block and captures its combinational r_data, on behalf of a command
//  client such as a debug host or monitor.
//  Sequences single-word reads and writes, and a torn-free 64-bit read of
//  the free-running cycle counter (CNT_H, CNT_L, CNT_H, retry on mismatch).
//  Sits beside the CPU pipeline, sharing its stall.
// PARAMETERS
//  ADDR_W      5   SPR address width
//  DATA_W      32  SPR word width
//  CNT_L_ADDR  0   SPR address of counter low word
//  CNT_H_ADDR  1   SPR address of counter high word
//  MAX_RETRY   3   counter re-read attempts before error
// PORTS
//  clk         in   1         clock, rising edge
//  rst         in   1         async reset, active-low
//  cmd_req     in   1         command valid
//  cmd_op      in   2         00 read, 01 write, 10 counter64, 11 reserved
//  cmd_addr    in   ADDR_W    target SPR (ignored for counter64)
//  cmd_wdata   in   DATA_W    write data
//  cmd_ack     out  1         1-cycle pulse: command accepted
//  rsp_valid   out  1         response held until rsp_ready
//  rsp_ready   in   1         client consumes response
//  rsp_data    out  2*DATA_W  {hi,lo}; single read -> {0,word}; write -> 0
//  rsp_err     out  1         reserved op or retry exhaustion
//  busy        out  1         FSM not in IDLE
//  stall       in   1         pipeline stall; SPR ignores access while 1
//  spr_addr    out  ADDR_W    to SPR addr
//  spr_wr      out  1         to SPR wr
//  spr_w_data  out  DATA_W    to SPR w_data
//  spr_r_data  in   DATA_W    from SPR r_data (combinational on spr_addr)
// BEHAVIOUR
//  Reset (rst=0, any time, async): every output is 0 and the FSM goes to
//   IDLE. An in-flight command is dropped and gets no response.
//  States: IDLE, WR, RD, CH1, CL, CH2, RSP.
//  IDLE, cmd_req=1: cmd_ack=1 that cycle; op and data are latched.
//   op 00 -> RD; 01 -> WR; 10 -> CH1 with retry count 0.
//   op 11 -> RSP with rsp_err=1 and rsp_data=0.
//  No command is accepted outside IDLE. cmd_ack=0 while busy.
//  spr_addr and spr_w_data are registered. spr_wr=1 only in WR.
//  Every access state holds its outputs while stall=1. It completes on the
//   first cycle with stall=0; r_data is sampled at that edge.
//  WR completes -> RSP, with rsp_data=0.
//  RD completes -> RSP, with rsp_data={0, r_data}.
//  CH1 completes: h1 <= r_data, go to CL.
//  CL completes: lo <= r_data, go to CH2.
//  CH2 completes:
//   r_data==h1 -> RSP, with rsp_data={h1, lo}.
//   Otherwise retry count +1: if the count reaches MAX_RETRY -> RSP with
//   rsp_err=1 and rsp_data={r_data, lo}; else back to CH1.
//  Latency with stall=0 (ack cycle = 0):
//   rsp_valid=1 from cycle 2 for read/write, from cycle 4 for counter64.
//  RSP: rsp_valid=1, data stable. Leaves to IDLE on the edge where
//   rsp_ready=1. rsp_valid and rsp_err clear in that same transition.
//  A cmd_req asserted in the cycle after the RSP handshake is accepted
//   normally.
//  busy=1 in every state except IDLE.
// TESTING
//  1. Write addr 5, data 32'hDEADBEEF, stall=0:
//     spr_wr=1 for exactly 1 cycle with addr 5; rsp_valid at cycle 2,
//     rsp_data=0.
//  2. Read addr 1 with SPR model returning 32'h12: rsp_data=64'h12 at
//     cycle 2. Hold rsp_ready=0 for 3 cycles: response stays stable, busy=1.
//  3. Write with stall=1 for 4 cycles: spr_wr held for 5 cycles total;
//     rsp_valid 1 cycle after stall falls.
//  4. Counter64, model H=7, L=32'hFFFFFFF0, H stable: rsp_data=
//     64'h7_FFFFFFF0, rsp_err=0, rsp_valid at cycle 4.
//  5. Counter64, model H changes 7->8 between reads, then stable: one retry
//     (3 more accesses). rsp_data={8, new L}. If H changes every time:
//     rsp_err=1 after MAX_RETRY.
//  6. rst low while in CL: all outputs 0 immediately. After release a
//     read command completes normally; op 11 gives rsp_err=1.

Source files
------------

// File: rtl/yutorina_spr_master.sv
// SPR access-port initiator: single-word read/write plus a torn-free 64-bit
// cycle-counter read (H, L, H with bounded retry) for a debug/monitor client.
module yutorina_spr_master #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_L_ADDR = 0,
    parameter int unsigned CNT_H_ADDR = 1,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_req,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                cmd_ack,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic                rsp_err,
    output logic                busy,
    input  logic                stall,
    output logic [ADDR_W-1:0]   spr_addr,
    output logic                spr_wr,
    output logic [DATA_W-1:0]   spr_w_data,
    input  logic [DATA_W-1:0]   spr_r_data
);

    localparam int unsigned RC_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_CH1, S_CL, S_CH2, S_RSP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   spr_addr_q, spr_addr_d;
    logic                spr_wr_q, spr_wr_d;
    logic [DATA_W-1:0]   spr_w_data_q, spr_w_data_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [2*DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0]   h1_q, h1_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [RC_W-1:0]     retry_q, retry_d;
    logic [RC_W-1:0]     retry_inc;

    always_comb begin
        state_d      = state_q;
        spr_addr_d   = spr_addr_q;
        spr_wr_d     = spr_wr_q;
        spr_w_data_d = spr_w_data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_data_d   = rsp_data_q;
        h1_d         = h1_q;
        lo_d         = lo_q;
        retry_d      = retry_q;
        retry_inc    = retry_q + RC_W'(1);

        case (state_q)
            S_IDLE: begin
                if (cmd_req) begin
                    spr_w_data_d = cmd_wdata;
                    retry_d      = '0;
                    case (cmd_op)
                        2'b00: begin
                            state_d    = S_RD;
                            spr_addr_d = cmd_addr;
                        end
                        2'b01: begin
                            state_d    = S_WR;
                            spr_addr_d = cmd_addr;
                            spr_wr_d   = 1'b1;
                        end
                        2'b10: begin
                            state_d    = S_CH1;
                            spr_addr_d = ADDR_W'(CNT_H_ADDR);
                        end
                        default: begin
                            state_d     = S_RSP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_data_d  = '0;
                        end
                    endcase
                end
            end
            S_WR: begin
                if (!stall) begin
                    state_d     = S_RSP;
                    spr_wr_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                end
            end
            S_RD: begin
                if (!stall) begin
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = {{DATA_W{1'b0}}, spr_r_data};
                end
            end
            S_CH1: begin
                if (!stall) begin
                    state_d    = S_CL;
                    h1_d       = spr_r_data;
                    spr_addr_d = ADDR_W'(CNT_L_ADDR);
                end
            end
            S_CL: begin
                if (!stall) begin
                    state_d    = S_CH2;
                    lo_d       = spr_r_data;
                    spr_addr_d = ADDR_W'(CNT_H_ADDR);
                end
            end
            S_CH2: begin
                // A matching second high word proves lo was not torn by a carry.
                if (!stall) begin
                    if (spr_r_data == h1_q) begin
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = {h1_q, lo_q};
                    end else if (retry_inc == RC_W'(MAX_RETRY)) begin
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = {spr_r_data, lo_q};
                    end else begin
                        state_d = S_CH1;
                        retry_d = retry_inc;
                    end
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            spr_addr_q   <= '0;
            spr_wr_q     <= 1'b0;
            spr_w_data_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            h1_q         <= '0;
            lo_q         <= '0;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            spr_addr_q   <= spr_addr_d;
            spr_wr_q     <= spr_wr_d;
            spr_w_data_q <= spr_w_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_data_q   <= rsp_data_d;
            h1_q         <= h1_d;
            lo_q         <= lo_d;
            retry_q      <= retry_d;
        end
    end

    // Ack is same-cycle with the request, forced low while reset is held.
    assign cmd_ack    = rst & cmd_req & (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign spr_addr   = spr_addr_q;
    assign spr_wr     = spr_wr_q;
    assign spr_w_data = spr_w_data_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_yutorina_spr_master.sv
// Bench for yutorina_spr_master: a per-command timeline model built from a
// list of SPR accesses, compared against the DUT every cycle.
module tb_yutorina_spr_master;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXR = 3;
    localparam int unsigned NC   = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_req;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_ack;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_data;
    logic          rsp_err;
    logic          busy;
    logic          stall;
    logic [AW-1:0] spr_addr;
    logic          spr_wr;
    logic [DW-1:0] spr_w_data;
    logic [DW-1:0] spr_r_data;

    always #5 clk = ~clk;

    yutorina_spr_master #(
        .ADDR_W(AW), .DATA_W(DW), .CNT_L_ADDR(0), .CNT_H_ADDR(1), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .rst(rst), .cmd_req(cmd_req), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_ack(cmd_ack), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .stall(stall), .spr_addr(spr_addr), .spr_wr(spr_wr), .spr_w_data(spr_w_data),
        .spr_r_data(spr_r_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // SPR model: k is the cycle index relative to the command's ack cycle.
    int          k = 0;
    int          hmode = 0;
    int          st_from = 0;
    int          st_len = 0;
    logic [31:0] mem [32];

    function automatic logic [31:0] spr_val(input logic [4:0] a, input int kk);
        if (hmode != 0 && a == 5'd1) begin
            case (hmode)
                1:       return 32'd7;
                2:       return (kk < 2) ? 32'd7 : 32'd8;
                default: return 32'(100 + kk);
            endcase
        end
        if (hmode != 0 && a == 5'd0) begin
            case (hmode)
                1:       return 32'hFFFF_FFF0;
                2:       return (kk < 4) ? 32'hFFFF_FFF0 : 32'h0000_0010;
                default: return 32'(32'hA000 + kk);
            endcase
        end
        return mem[a];
    endfunction

    always @(spr_addr or k or hmode) spr_r_data = spr_val(spr_addr, k);

    function automatic bit stalled(input int kk);
        return (kk >= st_from) && (kk < st_from + st_len);
    endfunction

    // Expected timeline of the current command.
    bit          exp_ack [NC];
    bit          exp_busy [NC];
    bit          exp_valid [NC];
    bit          exp_err [NC];
    bit          exp_acc [NC];
    bit          exp_wr [NC];
    logic [4:0]  exp_addr [NC];
    logic [63:0] exp_data;
    logic [31:0] exp_wd;
    bit          exp_rsp_err;
    int          rsp_start, rsp_end, mt, nwr;

    task automatic access(input logic [4:0] a, input bit wr, output logic [31:0] v);
        int tc;
        tc = mt;
        while (stalled(tc)) tc++;
        for (int i = mt; i <= tc; i++) begin
            exp_acc[i]  = 1'b1;
            exp_addr[i] = a;
            exp_wr[i]   = wr;
        end
        v  = spr_val(a, tc);
        mt = tc + 1;
    endtask

    task automatic build(input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd,
                         input int rd);
        logic [31:0] v, h1, lo, h2;
        int          n;
        bit          done;
        bit          err;
        logic [63:0] d;
        for (int i = 0; i < int'(NC); i++) begin
            exp_ack[i] = 0; exp_busy[i] = 0; exp_valid[i] = 0; exp_err[i] = 0;
            exp_acc[i] = 0; exp_wr[i] = 0; exp_addr[i] = '0;
        end
        exp_ack[0] = 1'b1;
        mt = 1; err = 1'b0; d = '0; exp_wd = wd;
        case (op)
            2'b00: begin access(a, 1'b0, v); d = {32'd0, v}; end
            2'b01: access(a, 1'b1, v);
            2'b10: begin
                n = 0; done = 1'b0;
                while (!done) begin
                    access(5'd1, 1'b0, h1);
                    access(5'd0, 1'b0, lo);
                    access(5'd1, 1'b0, h2);
                    if (h2 == h1) begin
                        d = {h1, lo}; done = 1'b1;
                    end else begin
                        n++;
                        if (n == int'(MAXR)) begin
                            err = 1'b1; d = {h2, lo}; done = 1'b1;
                        end
                    end
                end
            end
            default: err = 1'b1;
        endcase
        rsp_start = mt;
        rsp_end   = mt + rd;
        for (int i = 1; i <= rsp_end; i++) exp_busy[i] = 1'b1;
        for (int i = rsp_start; i <= rsp_end; i++) begin
            exp_valid[i] = 1'b1;
            exp_err[i]   = err;
        end
        exp_data    = d;
        exp_rsp_err = err;
        nwr = 0;
        for (int i = 0; i < int'(NC); i++) if (exp_wr[i]) nwr++;
    endtask

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ack", 64'(cmd_ack), 64'(exp_ack[k]));
            chk("busy", 64'(busy), 64'(exp_busy[k]));
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid[k]));
            chk("rsp_err", 64'(rsp_err), 64'(exp_err[k]));
            chk("spr_wr", 64'(spr_wr), 64'(exp_wr[k]));
            if (exp_valid[k]) chk("rsp_data", rsp_data, exp_data);
            if (exp_acc[k]) chk("spr_addr", 64'(spr_addr), 64'(exp_addr[k]));
            if (exp_wr[k]) chk("spr_w_data", 64'(spr_w_data), 64'(exp_wd));
        end
    end

    logic [1:0]  cur_op;
    logic [4:0]  cur_a;
    logic [31:0] cur_wd;
    bit          hold_req;

    // Command fields are scrambled after the ack cycle so only latched values count.
    task automatic drive();
        cmd_req   = (k == 0) || (hold_req && k <= rsp_end);
        cmd_op    = (k == 0) ? cur_op : 2'b11;
        cmd_addr  = (k == 0) ? cur_a : ~cur_a;
        cmd_wdata = (k == 0) ? cur_wd : ~cur_wd;
        stall     = stalled(k);
        rsp_ready = (k == rsp_end);
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd,
                             input int rd, input bit hold);
        @(posedge clk); #1;
        cur_op = op; cur_a = a; cur_wd = wd; hold_req = hold;
        build(op, a, wd, rd);
        k = 0;
        drive();
        chk_en = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
        k++;
        drive();
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd,
                           input int rd, input bit hold);
        start_cmd(op, a, wd, rd, hold);
        while (k < rsp_end) step();
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        chk_en = 1'b0; cmd_req = 1'b0; rsp_ready = 1'b0; stall = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_ack"}, 64'(cmd_ack), 64'd0);
        chk({nm, "_valid"}, 64'(rsp_valid), 64'd0);
        chk({nm, "_data"}, rsp_data, 64'd0);
        chk({nm, "_err"}, 64'(rsp_err), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_addr"}, 64'(spr_addr), 64'd0);
        chk({nm, "_wr"}, 64'(spr_wr), 64'd0);
        chk({nm, "_wdata"}, 64'(spr_w_data), 64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hCAFE_0000 | 32'(i);
        mem[1] = 32'h0000_0012;
        rst = 1'b0; cmd_req = 1'b1; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; stall = 1'b0; hold_req = 1'b0;
        #12;
        check_all_zero("reset");
        cmd_req = 1'b0;
        #11 rst = 1'b1;

        // Write addr 5 then a held read of addr 1, back to back.
        run_cmd(2'b01, 5'd5, 32'hDEAD_BEEF, 0, 1'b0);
        chk("t1_latency", 64'(rsp_start), 64'd2);
        chk("t1_wr_cycles", 64'(nwr), 64'd1);
        chk("t1_data", exp_data, 64'd0);
        run_cmd(2'b00, 5'd1, 32'h0, 3, 1'b1);
        chk("t2_latency", 64'(rsp_start), 64'd2);
        chk("t2_data", exp_data, 64'h12);

        // Write with stall held for 4 cycles.
        st_from = 1; st_len = 4;
        run_cmd(2'b01, 5'd9, 32'h0000_55AA, 1, 1'b0);
        chk("t3_wr_cycles", 64'(nwr), 64'd5);
        chk("t3_latency", 64'(rsp_start), 64'd6);

        st_len = 0; hmode = 1;
        run_cmd(2'b10, 5'd17, 32'h0, 0, 1'b0);
        chk("t4_latency", 64'(rsp_start), 64'd4);
        chk("t4_data", exp_data, 64'h0000_0007_FFFF_FFF0);
        chk("t4_err", 64'(exp_rsp_err), 64'd0);

        st_from = 2; st_len = 2;
        run_cmd(2'b10, 5'd0, 32'h0, 1, 1'b0);
        chk("t4b_latency", 64'(rsp_start), 64'd6);

        st_len = 0; hmode = 2;
        run_cmd(2'b10, 5'd0, 32'h0, 0, 1'b0);
        chk("t5_latency", 64'(rsp_start), 64'd7);
        chk("t5_data", exp_data, 64'h0000_0008_0000_0010);

        hmode = 3;
        run_cmd(2'b10, 5'd0, 32'h0, 2, 1'b0);
        chk("t5b_latency", 64'(rsp_start), 64'd10);
        chk("t5b_err", 64'(exp_rsp_err), 64'd1);
        chk("t5b_data", exp_data, {32'd109, 32'h0000_A008});
        go_idle();

        // Reset while the counter read is in CL.
        hmode = 1;
        start_cmd(2'b10, 5'd0, 32'h0, 0, 1'b0);
        step();
        step();
        #2;
        chk_en = 1'b0;
        chk("t6_busy_pre", 64'(busy), 64'd1);
        rst = 1'b0; cmd_req = 1'b1;
        #1;
        check_all_zero("rst_cl");
        @(posedge clk); #1;
        check_all_zero("rst_hold");
        cmd_req = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;

        hmode = 0;
        run_cmd(2'b00, 5'd3, 32'h0, 1, 1'b0);
        chk("t6_data", exp_data, 64'h0000_0000_CAFE_0003);
        run_cmd(2'b11, 5'd3, 32'h0, 2, 1'b0);
        chk("t6_resv_latency", 64'(rsp_start), 64'd1);
        chk("t6_resv_err", 64'(exp_rsp_err), 64'd1);
        go_idle();
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
